// File: rtl/i_decode.sv
// rtl/i_decode.sv - RV32I decode stage: instruction buffer, field/immediate decode, branch/JAL PC-offset loop
// Optional build macro I_DECODE_PERF_EN adds perf_dispatch / perf_br_taken counters.
module i_decode #(
  parameter int BUF_DEPTH = 4,
  parameter int PTR_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        fetch_hold,
  output logic        offset_valid,
  output logic [31:0] offset,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [6:0]  dec_opcode,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7,
  output logic [31:0] dec_imm,
  output logic        dec_illegal,
  input  logic        br_done,
  input  logic        br_taken,
  output logic        proto_err
`ifdef I_DECODE_PERF_EN
  ,
  output logic [31:0] perf_dispatch,
  output logic [31:0] perf_br_taken
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_e;

  logic [31:0]      buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_e           state_q;
  logic             pend_jal_q;
  logic [31:0]      pend_off_q;
  logic             offset_valid_q;
  logic [31:0]      offset_q;
  logic             proto_err_q;

  logic [31:0] head;
  logic [6:0]  head_op;
  logic        head_valid;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm_sel;
  logic        illegal;

  assign head       = buf_q[rd_ptr_q];
  assign head_op    = head[6:0];
  assign full       = (count_q == (PTR_W+1)'(BUF_DEPTH));
  assign head_valid = (state_q == ST_RUN) && (count_q != '0);
  assign pop        = head_valid && dec_ready;
  // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
  assign push       = inst_valid && (state_q == ST_RUN) && (!full || pop);
  assign drop       = inst_valid && ((state_q == ST_WAIT_BR) || (full && !pop));

  assign fetch_hold = (count_q >= (PTR_W+1)'(BUF_DEPTH - 1));

  assign imm_i = {{20{head[31]}}, head[31:20]};
  assign imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
  assign imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
  assign imm_u = {head[31:12], 12'b0};
  assign imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};

  // Immediate format selection and legality check from the head opcode.
  always_comb begin
    imm_sel = '0;
    illegal = 1'b0;
    case (head_op)
      OP_LUI, OP_AUIPC:         imm_sel = imm_u;
      OP_JAL:                   imm_sel = imm_j;
      OP_JALR, OP_LOAD, OP_IMM: imm_sel = imm_i;
      OP_BRANCH:                imm_sel = imm_b;
      OP_STORE:                 imm_sel = imm_s;
      OP_OP:                    imm_sel = '0;
      default:                  illegal = 1'b1;
    endcase
  end

  // Decoded fields are forced to zero whenever nothing is being offered to execute.
  assign dec_valid   = head_valid;
  assign dec_opcode  = head_valid ? head[6:0]   : '0;
  assign dec_rd      = head_valid ? head[11:7]  : '0;
  assign dec_rs1     = head_valid ? head[19:15] : '0;
  assign dec_rs2     = head_valid ? head[24:20] : '0;
  assign dec_funct3  = head_valid ? head[14:12] : '0;
  assign dec_funct7  = head_valid ? head[31:25] : '0;
  assign dec_imm     = head_valid ? imm_sel     : '0;
  assign dec_illegal = head_valid && illegal;

  assign offset_valid = offset_valid_q;
  assign offset       = offset_q;
  assign proto_err    = proto_err_q;

  // Buffer storage; contents are only observed through head_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= inst;
    end
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Control-flow FSM: parks after a JAL/branch dispatch and emits the one-shot PC correction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      pend_jal_q     <= 1'b0;
      pend_off_q     <= '0;
      offset_valid_q <= 1'b0;
      offset_q       <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      offset_valid_q <= 1'b0;
      if (drop) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (pop && (head_op == OP_JAL || head_op == OP_BRANCH)) begin
            state_q    <= ST_WAIT_BR;
            pend_jal_q <= (head_op == OP_JAL);
            // Fetch has already advanced the PC by 4 past the control-flow instruction.
            pend_off_q <= ((head_op == OP_JAL) ? imm_j : imm_b) - 32'd4;
          end
        end
        ST_WAIT_BR: begin
          if (pend_jal_q) begin
            offset_valid_q <= 1'b1;
            offset_q       <= pend_off_q;
            state_q        <= ST_RUN;
          end else if (br_done) begin
            offset_valid_q <= 1'b1;
            offset_q       <= br_taken ? pend_off_q : 32'd0;
            state_q        <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

`ifdef I_DECODE_PERF_EN
  logic [31:0] perf_dispatch_q;
  logic [31:0] perf_br_taken_q;

  assign perf_dispatch = perf_dispatch_q;
  assign perf_br_taken = perf_br_taken_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_dispatch_q <= '0;
      perf_br_taken_q <= '0;
    end else begin
      if (pop) begin
        perf_dispatch_q <= perf_dispatch_q + 32'd1;
      end
      if ((state_q == ST_WAIT_BR) && br_done && br_taken) begin
        perf_br_taken_q <= perf_br_taken_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_decode.sv
// tb/tb_i_decode.sv - scoreboard bench for i_decode
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic        fetch_hold;
  logic        offset_valid;
  logic [31:0] offset;
  logic        dec_valid;
  logic        dec_ready;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        br_done;
  logic        br_taken;
  logic        proto_err;

  always #5 clk = ~clk;

  i_decode dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .fetch_hold   (fetch_hold),
    .offset_valid (offset_valid),
    .offset       (offset),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_opcode   (dec_opcode),
    .dec_rd       (dec_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_funct3   (dec_funct3),
    .dec_funct7   (dec_funct7),
    .dec_imm      (dec_imm),
    .dec_illegal  (dec_illegal),
    .br_done      (br_done),
    .br_taken     (br_taken),
    .proto_err    (proto_err)
  );

  localparam logic [31:0] W_ADDI  = 32'h00500093;
  localparam logic [31:0] W_ADDI2 = 32'h00A10113;
  localparam logic [31:0] W_LUI   = 32'h123452B7;
  localparam logic [31:0] W_SW    = 32'h0020A423;
  localparam logic [31:0] W_ADD   = 32'h002081B3;
  localparam logic [31:0] W_ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] W_LW    = 32'hFFC0A303;
  localparam logic [31:0] W_BNE   = 32'hFE209EE3;
  localparam logic [31:0] W_JAL   = 32'h008000EF;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  dec_t        sb_q [$];
  logic [31:0] off_q [$];
  dec_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic dec_t model(input logic [31:0] w);
    dec_t d;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    d.op  = w[6:0];
    d.rd  = w[11:7];
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    d.f3  = w[14:12];
    d.f7  = w[31:25];
    d.imm = 32'd0;
    d.ill = 1'b0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin i12 = w[31:20]; d.imm = int'(i12); end
      7'h23: begin i12 = {w[31:25], w[11:7]}; d.imm = int'(i12); end
      7'h63: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; d.imm = int'(b13); end
      7'h37, 7'h17: d.imm = w & 32'hFFFFF000;
      7'h6F: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; d.imm = int'(j21); end
      7'h33: d.imm = 32'd0;
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  // Scoreboard monitor: decoded transfers and offset pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && dec_valid && dec_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_pop_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_fields", 32'({dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3}),
              32'({mon_e.op, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3}));
        check("sb_f7_ill", 32'({dec_funct7, dec_illegal}), 32'({mon_e.f7, mon_e.ill}));
        if (!mon_e.ill) check("sb_imm", dec_imm, mon_e.imm);
      end
    end
    if (rst && offset_valid) begin
      if (off_q.size() == 0) check("off_pop_underflow", 32'(off_q.size()), 32'd1);
      else                   check("off_value", offset, off_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input bit accepted);
    inst_valid = 1'b1;
    inst       = w;
    if (accepted) sb_q.push_back(model(w));
    step();
    inst_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb_q.delete();
    off_q.delete();
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] words [4];
    words[0] = W_LUI; words[1] = W_SW; words[2] = W_ADD; words[3] = W_ILL;
    rst = 1'b0; inst_valid = 1'b0; inst = '0; dec_ready = 1'b0;
    br_done = 1'b0; br_taken = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_fetch_hold", fetch_hold, 0);
    check("rst_offset_valid", offset_valid, 0);
    check("rst_offset", offset, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_fields", 32'({dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7, dec_illegal}), 0);
    check("rst_imm", dec_imm, 0);
    step();
    rst = 1'b1;
    step();

    // Single addi, zero-latency decode
    dec_ready = 1'b1;
    push(W_ADDI, 1);
    @(negedge clk);
    check("t1_valid", dec_valid, 1);
    check("t1_rd", dec_rd, 1);
    check("t1_rs1", dec_rs1, 0);
    check("t1_imm", dec_imm, 5);
    check("t1_illegal", dec_illegal, 0);
    step();
    @(negedge clk);
    check("t1_valid_after", dec_valid, 0);
    step();

    // Fill buffer, overflow, drain in order
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(words[i], 1);
      @(negedge clk);
      check("t2_fetch_hold", fetch_hold, (i >= 2) ? 32'd1 : 32'd0);
      step();
    end
    check("t2_proto_before", proto_err, 0);
    push(W_LW, 0);
    @(negedge clk);
    check("t2_proto_err", proto_err, 1);
    check("t2_head_op", dec_opcode, W_LUI[6:0]);
    check("t2_head_imm", dec_imm, 32'h12345000);
    step();
    dec_ready = 1'b1;
    n = 0;
    while (dec_valid && n < 20) begin step(); n++; end
    check("t2_drain_timeout", dec_valid, 0);
    check("t2_sb_empty", 32'(sb_q.size()), 0);
    check("t2_hold_released", fetch_hold, 0);

    // Taken bne
    do_reset();
    dec_ready = 1'b1;
    push(W_BNE, 1);
    @(negedge clk);
    check("t3_valid", dec_valid, 1);
    check("t3_bimm", dec_imm, 32'hFFFFFFFC);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_wait_valid", dec_valid, 0);
      check("t3_wait_offv", offset_valid, 0);
      step();
    end
    br_done = 1'b1; br_taken = 1'b1;
    off_q.push_back(32'hFFFFFFF8);
    step();
    br_done = 1'b0;
    @(negedge clk);
    check("t3_offv", offset_valid, 1);
    check("t3_off", offset, 32'hFFFFFFF8);
    step();
    @(negedge clk);
    check("t3_offv_one_cycle", offset_valid, 0);
    check("t3_off_hold", offset, 32'hFFFFFFF8);
    step();

    // Not-taken bne then a normal instruction
    push(W_BNE, 1);
    step();
    step();
    br_done = 1'b1; br_taken = 1'b0;
    off_q.push_back(32'd0);
    step();
    br_done = 1'b0;
    @(negedge clk);
    check("t4_offv", offset_valid, 1);
    check("t4_off", offset, 0);
    step();
    push(W_ADDI2, 1);
    @(negedge clk);
    check("t4_valid", dec_valid, 1);
    check("t4_imm", dec_imm, 10);
    step();
    step();

    // JAL self-resolves; inst_valid during branch wait is a protocol error
    off_q.push_back(32'd4);
    push(W_JAL, 1);
    @(negedge clk);
    check("t5_jal_valid", dec_valid, 1);
    check("t5_jimm", dec_imm, 8);
    step();
    n = 0;
    while (!offset_valid && n < 10) begin step(); n++; end
    check("t5_jal_offv", offset_valid, 1);
    check("t5_jal_off", offset, 4);
    step();
    check("t5_proto_before", proto_err, 0);
    push(W_BNE, 1);
    step();
    push(W_ADDI, 0);
    @(negedge clk);
    check("t5_proto_err", proto_err, 1);
    check("t5_wait_valid", dec_valid, 0);
    step();
    br_done = 1'b1; br_taken = 1'b1;
    off_q.push_back(32'hFFFFFFF8);
    step();
    br_done = 1'b0;
    step();
    @(negedge clk);
    check("t5_discarded", dec_valid, 0);
    step();

    // Async reset in WAIT_BR with two buffered words
    dec_ready = 1'b0;
    push(W_BNE, 1);
    push(W_ADDI, 1);
    push(W_LUI, 1);
    check("t6_fetch_hold", fetch_hold, 1);
    dec_ready = 1'b1;
    step();
    @(negedge clk);
    check("t6_wait_valid", dec_valid, 0);
    #2;
    rst = 1'b0;
    sb_q.delete();
    off_q.delete();
    #1;
    check("t6_rst_valid", dec_valid, 0);
    check("t6_rst_hold", fetch_hold, 0);
    check("t6_rst_offv", offset_valid, 0);
    check("t6_rst_off", offset, 0);
    check("t6_rst_proto", proto_err, 0);
    check("t6_rst_imm", dec_imm, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_done  = (i == 1);
      br_taken = 1'b1;
      @(negedge clk);
      check("t6_post_valid", dec_valid, 0);
      check("t6_post_offv", offset_valid, 0);
      step();
    end
    br_done = 1'b0;

    check("end_sb_empty", 32'(sb_q.size()), 0);
    check("end_off_empty", 32'(off_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i_decode.md
Name: i_decode

Overview:
- Sits directly downstream of instruction fetch.
- Buffers fetched instruction words, decodes RV32I fields and immediates, and hands decoded instructions to execute over a valid/ready handshake.
- Closes the control-flow loop: produces the one-shot `offset_valid`/`offset` that fetch applies to its PC after JAL and conditional branches.

Parameters:
- BUF_DEPTH, 4: instruction buffer entries; power of two, >=2.
- PTR_W, 2: log2(BUF_DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- inst_valid  in  1  one-cycle pulse from fetch per fetched word.
- inst  in  32  fetched instruction word; sampled when inst_valid=1.
- fetch_hold  out  1  buffer has <=1 free entry; fetch must not start a new request.
- offset_valid  out  1  one-cycle pulse; fetch adds offset to its PC once.
- offset  out  32  signed PC correction; valid with offset_valid.
- dec_valid  out  1  decoded instruction available.
- dec_ready  in  1  execute accepts; transfer on dec_valid&&dec_ready.
- dec_opcode  out  7  inst[6:0].
- dec_rd  out  5  inst[11:7].
- dec_rs1  out  5  inst[19:15].
- dec_rs2  out  5  inst[24:20].
- dec_funct3  out  3  inst[14:12].
- dec_funct7  out  7  inst[31:25].
- dec_imm  out  32  sign-extended immediate: I/S/B/U/J by opcode; 0 for R-type.
- dec_illegal  out  1  opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}.
- br_done  in  1  execute has resolved the last dispatched branch; one-cycle pulse.
- br_taken  in  1  branch outcome; valid with br_done.
- proto_err  out  1  sticky; set on push to a full buffer or inst_valid in WAIT_BR.

Behaviour:
- Reset (rst=0, async): buffer empty, pointers/count 0, state RUN. All outputs 0: fetch_hold, offset_valid, offset, dec_valid, all dec_* fields, proto_err.
- Buffer: circular FIFO, count 0..BUF_DEPTH.
  - Push on inst_valid when state=RUN and not full.
  - Pop on dec_valid&&dec_ready.
  - Simultaneous push+pop: count unchanged; allowed when full.
  - Pointers wrap modulo BUF_DEPTH.
- Push when full and no pop: word dropped, proto_err=1.
- fetch_hold = (count >= BUF_DEPTH-1), combinational from registered count.
- Decode is combinational from the head entry; zero added latency.
  - A word pushed at edge N is visible on dec_* after edge N when the buffer was empty.
- dec_valid = (state==RUN) && (count!=0). dec_* hold stable while dec_valid=1 and dec_ready=0.
- FSM states: RUN, WAIT_BR.
- RUN → WAIT_BR on dispatch of opcode 1100011 (BRANCH) or 1101111 (JAL).
  - JAL: offset_valid=1 and offset=J-imm-4 on the edge after dispatch; state returns to RUN that same edge.
  - BRANCH: stay in WAIT_BR until br_done.
- WAIT_BR, branch:
  - dec_valid=0.
  - Any inst_valid is discarded and sets proto_err; fetch stalls on control flow.
  - On br_done, the next edge sets offset_valid=1 with offset = br_taken ? B-imm-4 : 0, state=RUN.
  - The not-taken pulse with offset 0 is still issued; it releases fetch.
- The -4 compensates for the +4 fetch already applied to the branch PC.
  - Arithmetic is 32-bit two's complement, wrap ignored.
  - Example: B-imm=0 with taken gives offset=0xFFFFFFFC.
- offset_valid is high exactly one cycle; offset holds its last value afterwards.
- br_done while in RUN is ignored.
- JALR is dispatched as a normal instruction; no offset is generated, execute owns it.
- dec_illegal instructions are dispatched normally; execute handles the trap. They do not change the FSM.
- Reset mid-WAIT_BR or with a non-empty buffer: everything is cleared immediately; no offset pulse is emitted.

Optional Feature:
- Macro: I_DECODE_PERF_EN.
- With the macro: adds outputs `perf_dispatch` (32) and `perf_br_taken` (32), both reset to 0.
  - perf_dispatch increments on each dec_valid&&dec_ready.
  - perf_br_taken increments on br_done&&br_taken while in WAIT_BR.
  - Both wrap at 2^32.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) with dec_ready=1 → next cycle dec_valid=1, dec_rd=1, dec_rs1=0, dec_imm=5, dec_illegal=0; one cycle later dec_valid=0.
- dec_ready=0, push 4 words → count=4; fetch_hold=1 from the 3rd push onward; a 5th push sets proto_err=1 and dec_* still show word 1; release dec_ready → words 1-4 come out in order.
- Push bne 0xFE209EE3 (B-imm=-4), dispatch, hold 3 cycles with dec_valid=0, pulse br_done with br_taken=1 → next cycle offset_valid=1 for exactly 1 cycle, offset=0xFFFFFFF8.
- Same bne with br_taken=0 → offset_valid=1, offset=0; state RUN; a following push is decoded normally.
- Push jal 0x008000EF (J-imm=8) → after dispatch offset_valid=1, offset=4, no br_done needed; inst_valid during WAIT_BR of a branch → proto_err=1.
- Drop rst mid-WAIT_BR with 2 buffered words → all outputs 0 asynchronously; after release, dec_valid=0 and no offset pulse is emitted.
